// File: rtl/if_id_stage.sv
// IF/ID pipeline register: captures the fetched word, its PC and link value,
// fetch-address exception and delay-slot status for the decode stage.
module if_id_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_3000,
    parameter logic [31:0] IM_LO    = 32'h0000_3000,
    parameter logic [31:0] IM_HI    = 32'h0000_6FFF,
    parameter logic [4:0]  EXC_ADEL = 5'd4
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [31:0] pc_f,
    input  logic [31:0] instr_f,
    input  logic        stall,
    input  logic        stall2,
    input  logic        block,
    input  logic        flush,
    input  logic        is_branch_d,
    output logic [31:0] instr_d,
    output logic [31:0] pc_d,
    output logic [31:0] pc8_d,
    output logic        valid_d,
    output logic        bd_d,
    output logic        exc_d,
    output logic [4:0]  exccode_d
);

    logic        w_hold;
    logic        w_bad_f;
    logic        w_bd_f;

    logic [31:0] r_instr;
    logic [31:0] r_pc;
    logic [31:0] r_pc8;
    logic        r_valid;
    logic        r_bd;
    logic        r_exc;
    logic [4:0]  r_exccode;

    // Same enable as the PC register so PC and IF/ID freeze together.
    assign w_hold  = stall | stall2 | block;
    assign w_bad_f = (pc_f[1:0] != 2'b00) | (pc_f < IM_LO) | (pc_f > IM_HI);
    assign w_bd_f  = r_valid & is_branch_d;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_instr   <= 32'h0;
            r_pc      <= RESET_PC;
            r_pc8     <= RESET_PC + 32'd8;
            r_valid   <= 1'b0;
            r_bd      <= 1'b0;
            r_exc     <= 1'b0;
            r_exccode <= 5'd0;
        end else if (flush) begin
            // Bubble keeps the F-stage PC so the redirect target stays visible.
            r_instr   <= 32'h0;
            r_pc      <= pc_f;
            r_pc8     <= pc_f + 32'd8;
            r_valid   <= 1'b0;
            r_bd      <= 1'b0;
            r_exc     <= 1'b0;
            r_exccode <= 5'd0;
        end else if (!w_hold) begin
            r_pc    <= pc_f;
            r_pc8   <= pc_f + 32'd8;
            r_valid <= 1'b1;
            r_bd    <= w_bd_f;
            if (w_bad_f) begin
                r_instr   <= 32'h0;
                r_exc     <= 1'b1;
                r_exccode <= EXC_ADEL;
            end else begin
                r_instr   <= instr_f;
                r_exc     <= 1'b0;
                r_exccode <= 5'd0;
            end
        end
    end

    assign instr_d   = r_instr;
    assign pc_d      = r_pc;
    assign pc8_d     = r_pc8;
    assign valid_d   = r_valid;
    assign bd_d      = r_bd;
    assign exc_d     = r_exc;
    assign exccode_d = r_exccode;

endmodule

// File: tb/tb_if_id_stage.sv
// Bench for if_id_stage: behavioural model checked every negedge, plus
// literal expectations at key points of a directed sequence.
module tb_if_id_stage;

    logic        clock = 1'b0;
    logic        reset;
    logic [31:0] pc_f;
    logic [31:0] instr_f;
    logic        stall, stall2, block, flush, is_branch_d;
    logic [31:0] instr_d, pc_d, pc8_d;
    logic        valid_d, bd_d, exc_d;
    logic [4:0]  exccode_d;

    int n_pass  = 0;
    int n_total = 0;
    bit done    = 0;

    // model state
    logic [31:0] m_instr, m_pc, m_pc8;
    logic        m_valid, m_bd, m_exc;
    logic [4:0]  m_code;

    if_id_stage dut (
        .clock(clock), .reset(reset), .pc_f(pc_f), .instr_f(instr_f),
        .stall(stall), .stall2(stall2), .block(block), .flush(flush),
        .is_branch_d(is_branch_d), .instr_d(instr_d), .pc_d(pc_d),
        .pc8_d(pc8_d), .valid_d(valid_d), .bd_d(bd_d), .exc_d(exc_d),
        .exccode_d(exccode_d)
    );

    always #5 clock = ~clock;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    endtask

    function automatic bit legal_fetch(input logic [31:0] a);
        return (a % 4 == 0) && (a >= 32'h3000) && (a <= 32'h6FFF);
    endfunction

    initial begin
        m_instr = 0; m_pc = 32'h3000; m_pc8 = 32'h3008;
        m_valid = 0; m_bd = 0; m_exc = 0; m_code = 0;
    end

    always @(posedge clock or posedge reset) begin
        if (reset) begin
            m_instr = 0; m_pc = 32'h3000; m_pc8 = 32'h3008;
            m_valid = 0; m_bd = 0; m_exc = 0; m_code = 0;
        end else if (flush) begin
            m_instr = 0; m_pc = pc_f; m_pc8 = pc_f + 32'd8;
            m_valid = 0; m_bd = 0; m_exc = 0; m_code = 0;
        end else if (!(stall || stall2 || block)) begin
            m_bd    = m_valid && is_branch_d;
            m_pc    = pc_f;
            m_pc8   = pc_f + 32'd8;
            m_valid = 1;
            if (legal_fetch(pc_f)) begin
                m_instr = instr_f; m_exc = 0; m_code = 0;
            end else begin
                m_instr = 0; m_exc = 1; m_code = 5'd4;
            end
        end
    end

    always @(negedge clock) begin
        if (!done) begin
            chk("m_instr", instr_d, m_instr);
            chk("m_pc", pc_d, m_pc);
            chk("m_pc8", pc8_d, m_pc8);
            chk("m_valid", 32'(valid_d), 32'(m_valid));
            chk("m_bd", 32'(bd_d), 32'(m_bd));
            chk("m_exc", 32'(exc_d), 32'(m_exc));
            chk("m_code", 32'(exccode_d), 32'(m_code));
        end
    end

    task automatic tick();
        @(posedge clock);
        #2;
    endtask

    task automatic drv(input logic [31:0] pc, input logic [31:0] ins,
                       input logic s, input logic s2, input logic b,
                       input logic f, input logic br);
        pc_f = pc; instr_f = ins; stall = s; stall2 = s2; block = b;
        flush = f; is_branch_d = br;
    endtask

    initial begin
        reset = 0;
        drv(32'h3000, 32'h1111_0000, 0, 0, 0, 0, 0);
        #1 reset = 1;
        #2;
        chk("rst_pc", pc_d, 32'h3000);
        chk("rst_pc8", pc8_d, 32'h3008);
        chk("rst_valid", 32'(valid_d), 32'd0);
        tick();
        reset = 0;

        // straight-line fetch
        drv(32'h3000, 32'hAAAA_0001, 0, 0, 0, 0, 0); tick();
        chk("sl0_instr", instr_d, 32'hAAAA_0001);
        chk("sl0_valid", 32'(valid_d), 32'd1);
        drv(32'h3004, 32'hAAAA_0002, 0, 0, 0, 0, 0); tick();
        chk("sl1_pc", pc_d, 32'h3004);
        chk("sl1_pc8", pc8_d, 32'h300C);
        drv(32'h3008, 32'hAAAA_0003, 0, 0, 0, 0, 0); tick();

        // each hold source alone for three cycles
        for (int src = 0; src < 3; src++) begin
            for (int k = 0; k < 3; k++) begin
                drv(32'h3100 + 32'(4 * k), 32'hBEEF_0000 + 32'(k),
                    src == 0, src == 1, src == 2, 0, 0);
                tick();
                chk("hold_pc", pc_d, 32'h3008);
                chk("hold_instr", instr_d, 32'hAAAA_0003);
            end
        end
        // release: current fetch loads; this is a beq in D
        drv(32'h300C, 32'h1000_0004, 0, 0, 0, 0, 0); tick();
        chk("rel_pc", pc_d, 32'h300C);
        drv(32'h3010, 32'hCCCC_0001, 0, 0, 0, 0, 1); tick();
        chk("bd_set", 32'(bd_d), 32'd1);
        chk("bd_pc", pc_d, 32'h3010);
        drv(32'h3014, 32'hCCCC_0002, 0, 0, 0, 0, 0); tick();
        chk("bd_clr", 32'(bd_d), 32'd0);

        // bad fetches
        drv(32'h3002, 32'hDDDD_0001, 0, 0, 0, 0, 0); tick();
        chk("mis_exc", 32'(exc_d), 32'd1);
        chk("mis_code", 32'(exccode_d), 32'd4);
        chk("mis_instr", instr_d, 32'h0);
        drv(32'h7000, 32'hDDDD_0002, 0, 0, 0, 0, 0); tick();
        chk("hi_exc", 32'(exc_d), 32'd1);
        drv(32'h6FFC, 32'hDDDD_0003, 0, 0, 0, 0, 0); tick();
        chk("top_exc", 32'(exc_d), 32'd0);
        chk("top_instr", instr_d, 32'hDDDD_0003);
        drv(32'h2FFC, 32'hDDDD_0004, 0, 0, 0, 0, 0); tick();
        chk("lo_exc", 32'(exc_d), 32'd1);
        drv(32'hFFFF_FFFC, 32'hDDDD_0005, 0, 0, 0, 0, 0); tick();
        chk("wrap_pc8", pc8_d, 32'h0000_0004);
        drv(32'h3020, 32'hEEEE_0001, 0, 0, 0, 0, 0); tick();
        // bad address while held is ignored
        drv(32'h3001, 32'hEEEE_0002, 1, 0, 0, 0, 0); tick();
        chk("hbad_exc", 32'(exc_d), 32'd0);
        chk("hbad_pc", pc_d, 32'h3020);

        // flush overrides stall
        drv(32'h4180, 32'hEEEE_0003, 1, 0, 0, 1, 1); tick();
        chk("fl_valid", 32'(valid_d), 32'd0);
        chk("fl_instr", instr_d, 32'h0);
        chk("fl_pc", pc_d, 32'h4180);
        chk("fl_pc8", pc8_d, 32'h4188);
        chk("fl_bd", 32'(bd_d), 32'd0);
        chk("fl_exc", 32'(exc_d), 32'd0);

        // reset between edges while valid, with a stall pending
        drv(32'h3040, 32'hF0F0_0001, 0, 0, 0, 0, 0); tick();
        chk("pre_rst_valid", 32'(valid_d), 32'd1);
        drv(32'h3044, 32'hF0F0_0002, 1, 0, 0, 0, 0);
        #1 reset = 1;
        #1;
        chk("mrst_pc", pc_d, 32'h3000);
        chk("mrst_pc8", pc8_d, 32'h3008);
        chk("mrst_instr", instr_d, 32'h0);
        chk("mrst_valid", 32'(valid_d), 32'd0);
        tick();
        reset = 0;
        tick();
        chk("post_rst_hold", 32'(valid_d), 32'd0);
        drv(32'h3048, 32'hF0F0_0003, 0, 0, 0, 0, 0); tick();
        chk("post_rst_load", pc_d, 32'h3048);
        tick();

        @(negedge clock);
        #1 done = 1;
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/if_id_stage.md
# if_id_stage

Fetch/decode boundary register for the 5-stage MIPS pipeline. It latches the word read from instruction memory at the current PC, the PC and PC+8 link value, plus fetch-exception and branch-delay-slot status, and presents them to the decode stage one cycle later. It obeys the same hold sources as the PC register, so PC and IF/ID freeze together. It also turns exception and `eret` redirects into a clean bubble.

## Interface
Parameters:
- `RESET_PC`, 32'h0000_3000: PC value shown in decode after reset.
- `IM_LO`, 32'h0000_3000: lowest legal fetch address, inclusive.
- `IM_HI`, 32'h0000_6FFF: highest legal fetch address, inclusive.
- `EXC_ADEL`, 5'd4: exception code reported for a bad fetch address.

Ports:
- `clock`  in  1: clock. Rising-edge.
- `reset`  in  1: reset, asynchronous, active-high.
- `pc_f`  in  32: current fetch PC, driven by the PC register.
- `instr_f`  in  32: instruction-memory read data at `pc_f`, combinational.
- `stall`  in  1: data-hazard stall from the hazard unit.
- `stall2`  in  1: second hazard-stall source.
- `block`  in  1: multiply/divide busy hold.
- `flush`  in  1: exception or `eret` redirect. Discard the F-stage instruction.
- `is_branch_d`  in  1: decoder flag. The instruction now in D is a branch or jump.
- `instr_d`  out  32: instruction presented to decode.
- `pc_d`  out  32: PC of `instr_d`.
- `pc8_d`  out  32: `pc_d + 8`, the link value for jal/jalr/bgezal.
- `valid_d`  out  1: `instr_d` is a real instruction, not a bubble.
- `bd_d`  out  1: `instr_d` sits in a branch delay slot.
- `exc_d`  out  1: the fetch of `instr_d` raised an exception.
- `exccode_d`  out  5: exception code. Meaningful only when `exc_d` = 1.

## Operation
- `hold = stall | stall2 | block`. This is the same enable condition as the PC register.
- Fetch check, combinational on `pc_f`: `bad_f = (pc_f[1:0] != 0) | (pc_f < IM_LO) | (pc_f > IM_HI)`. Compares are unsigned, 32-bit.
- Delay-slot flag for the F instruction: `bd_f = valid_d & is_branch_d`.
- Next-state priority on each rising clock edge, highest first:
  1. `flush` = 1: load a bubble. `instr_d`=0, `valid_d`=0, `bd_d`=0, `exc_d`=0, `exccode_d`=0, `pc_d`=`pc_f`, `pc8_d`=`pc_f`+8. Flush overrides `hold`.
  2. `hold` = 1: every output register keeps its value.
  3. Otherwise, load: `pc_d`=`pc_f`, `pc8_d`=`pc_f`+8, `valid_d`=1, `bd_d`=`bd_f`.
     - If `bad_f` = 1: `instr_d`=32'h0 (forced nop), `exc_d`=1, `exccode_d`=`EXC_ADEL`.
     - If `bad_f` = 0: `instr_d`=`instr_f`, `exc_d`=0, `exccode_d`=0.
- `pc8_d` addition is modulo 2^32. 32'hFFFF_FFFC + 8 wraps to 32'h0000_0004.
- No internal state beyond the output registers. `bd_f` is computed from the registered `valid_d` and the decoder's `is_branch_d`.

## Timing
- Latency is one cycle: F-stage values at edge N appear on the outputs after edge N.
- Reset is asynchronous and takes effect immediately, with no wait for a clock edge. While asserted: `pc_d`=`RESET_PC`, `pc8_d`=`RESET_PC`+8, `instr_d`=0, and `valid_d`, `bd_d`, `exc_d`, `exccode_d` are all 0.
- On reset release, the first load happens at the first edge with `hold`=0.
- Reset asserted mid-stall or mid-flush overrides everything. No stale value may survive.
- Flush and hold in the same cycle: the flush result is loaded.
- A bad `pc_f` during `hold` is not captured. It is evaluated only on the load edge.
- Outputs are registered only. There is no combinational path from any input to any output.

## Test plan
- Reset mid-run: assert `reset` between clock edges while `valid_d`=1 -> outputs change immediately to `pc_d`=0x3000, `pc8_d`=0x3008, `instr_d`=0, `valid_d`=0.
- Straight-line fetch: `pc_f`=0x3000/0x3004/0x3008 with distinct `instr_f`, no hold -> each appears one edge later, e.g. `pc_d`=0x3004 and `pc8_d`=0x300C on the second edge, `valid_d`=1.
- Hold: assert `stall`, then `stall2`, then `block`, one at a time, for 3 cycles each while `pc_f`/`instr_f` change -> outputs frozen at their pre-hold values. Release -> the current `pc_f` is loaded.
- Delay slot: D holds a beq (`is_branch_d`=1, `valid_d`=1) and `pc_f`=0x3010 -> next edge gives `bd_d`=1. Following instruction, with `is_branch_d`=0 -> `bd_d`=0.
- Bad fetch: `pc_f`=0x3002 -> `exc_d`=1, `exccode_d`=4, `instr_d`=0. `pc_f`=0x7000 -> same. `pc_f`=0x6FFC -> `exc_d`=0.
- Flush during stall: `stall`=1 and `flush`=1 with `pc_f`=0x4180 -> `valid_d`=0, `instr_d`=0, `pc_d`=0x4180, `bd_d`=0, `exc_d`=0.
